ex_mem_loader: RTL and testbench
================================

Name: ex_mem_loader

Overview:
- Boot/reload sequencer for the riscv core.
- Accepts a 32-bit word stream over a valid/ready handshake, packs word pairs, and writes them into instruction memory, then data memory, through the core's external-load port: enable_load_ex_mem, Inst/DataExMemAddress, Data1/Data2.
- Holds the core halted while loading and releases it when done.
- Sits between the testbench/host interface and the riscv top level.

Parameters:
ADDR_W, 9, width of inst/data memory pair address
DATA_W, 32, stream and memory word width
INST_DEPTH, 512, number of instruction pair addresses
DATA_DEPTH, 512, number of data pair addresses

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  begin load session (sampled in IDLE, RUN, ERROR)
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&s_ready
s_data  in  DATA_W  stream word
s_last  in  1  last word of current section (inst, then data)
enable_load_ex_mem  out  1  level; high for the whole load session
enable_halt  out  1  core halt; high except in RUN
inst_we  out  1  one-cycle instruction pair write strobe
inst_addr  out  ADDR_W  instruction pair address
inst_data1  out  DATA_W  first word of pair
inst_data2  out  DATA_W  second word of pair
data_we  out  1  one-cycle data pair write strobe
data_addr  out  ADDR_W  data pair address
data_data1  out  DATA_W  first word
data_data2  out  DATA_W  second word
busy  out  1  high in any load state
done  out  1  high in RUN
err  out  1  sticky overflow flag, cleared by start or reset

Behaviour:
- Reset (async):
  - State IDLE.
  - enable_halt=1; all other outputs 0.
  - Addresses 0, data registers 0.
- States: IDLE, I_W1, I_W2, I_WR, D_W1, D_W2, D_WR, RUN, ERROR.
- IDLE/RUN/ERROR + start:
  - Go to I_W1; clear err; zero both address counters.
  - enable_halt=1 and enable_load_ex_mem=1 from the next cycle.
- s_ready: high only in I_W1, I_W2, D_W1, D_W2; low in all other states.
- I_W1, word accepted:
  - Word goes to inst_data1.
  - If s_last=1: inst_data2<=0, go to I_WR, mark section end.
  - Else go to I_W2.
- I_W2, word accepted:
  - Word goes to inst_data2; go to I_WR.
  - Section end is set if s_last=1.
- I_WR (one cycle, no stream acceptance):
  - inst_we=1; inst_addr and inst_data1/2 stable this cycle.
  - Next cycle, if section end: go to D_W1 with data_addr=0.
  - Else, if inst_addr==INST_DEPTH-1: go to ERROR, err=1.
  - Else: inst_addr+1, go to I_W1.
- D_W1, D_W2, D_WR: identical behaviour using the data_* outputs and DATA_DEPTH.
  - Section end in D_WR: go to RUN.
  - Overflow in D_WR: go to ERROR.
- RUN:
  - enable_load_ex_mem=0, enable_halt=0, done=1.
  - The core executes.
- ERROR:
  - enable_halt=1, enable_load_ex_mem=0, err=1, s_ready=0.
  - Waits for start.
- Latency:
  - Each pair takes a minimum of 3 cycles (W1, W2, WR).
  - A single-word final pair takes 2 cycles.
  - Each write strobe is exactly 1 cycle.
- Stream stall: s_valid low holds the current state; no timeout.
- Addresses hold their last value after a section; they are cleared only by start or reset.
- start during a load state is ignored.
- Reset mid-load: the session is aborted immediately; already-written memory contents are undefined to the core until the next load.
- A zero-length section is not supported: each section needs at least 1 word.
- Only one of inst_we/data_we is ever high in a cycle.

Test Plan:
1. Reset, then start.
   - Send inst words 0x00000013, 0x00100093, 0x00200113 (last), then data 0xDEADBEEF, 0x12345678 (last).
   - Required: inst_we at addr 0 with (0x13, 0x00100093).
   - Required: inst_we at addr 1 with (0x00200113, 0).
   - Required: data_we at addr 0 with (0xDEADBEEF, 0x12345678).
   - Required: then done=1, enable_halt=0, enable_load_ex_mem=0.
2. Backpressure/stall:
   - Toggle s_valid randomly.
   - Required: s_ready=0 in every WR cycle; no word lost or duplicated; pair contents match stream order.
3. Overflow:
   - INST_DEPTH=4; send 10 inst words without s_last.
   - Required: 4 inst_we strobes (addr 0..3), then ERROR, err=1, enable_halt=1, s_ready=0.
4. Reload from RUN:
   - Assert start.
   - Required: enable_halt=1 next cycle, err/done=0, inst_addr restarts at 0.
5. Reset mid-load:
   - Assert reset during D_W2.
   - Required: outputs immediately return to reset values (enable_halt=1, others 0), state IDLE.
6. start asserted during I_W2:
   - Required: no effect; the sequence continues unchanged.

Source files
------------

// File: rtl/ex_mem_loader.sv
// Boot/reload sequencer: packs a 32-bit word stream into pairs and writes them to inst, then data memory.
// Latency: 3 cycles per full pair (W1, W2, WR), 2 cycles for a single-word final pair; strobes last 1 cycle.
// Backpressure: s_ready is low in WR/IDLE/RUN/ERROR; s_valid low simply holds the current state.
//
// Ports: clk/reset (async active-high); start begins a session from IDLE/RUN/ERROR;
//   s_valid/s_ready/s_data/s_last word stream (s_last closes the inst section, then the data section);
//   enable_load_ex_mem/enable_halt drive the core's load and halt controls;
//   inst_*/data_* carry the pair write strobe, pair address and the two words;
//   busy (loading), done (core running), err (sticky overflow).
module ex_mem_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int INST_DEPTH = 512,
  parameter int DATA_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              enable_load_ex_mem,
  output logic              enable_halt,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data1,
  output logic [DATA_W-1:0] inst_data2,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_data1,
  output logic [DATA_W-1:0] data_data2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, I_W1, I_W2, I_WR, D_W1, D_W2, D_WR, RUN, ERROR
  } state_t;

  state_t              r_state;
  logic                r_sec_end;   // the pair being written closes the current section
  logic                r_err;
  logic [ADDR_W-1:0]   r_inst_addr;
  logic [ADDR_W-1:0]   r_data_addr;
  logic [DATA_W-1:0]   r_inst_d1;
  logic [DATA_W-1:0]   r_inst_d2;
  logic [DATA_W-1:0]   r_data_d1;
  logic [DATA_W-1:0]   r_data_d2;

  logic w_accept;
  logic w_inst_full;
  logic w_data_full;

  assign w_accept    = s_valid && s_ready;
  assign w_inst_full = (r_inst_addr == ADDR_W'(INST_DEPTH - 1));
  assign w_data_full = (r_data_addr == ADDR_W'(DATA_DEPTH - 1));

  // All control outputs are pure decodes of the registered state.
  assign s_ready            = (r_state == I_W1) || (r_state == I_W2) ||
                              (r_state == D_W1) || (r_state == D_W2);
  assign inst_we            = (r_state == I_WR);
  assign data_we            = (r_state == D_WR);
  assign busy               = s_ready || inst_we || data_we;
  assign enable_load_ex_mem = busy;
  assign done               = (r_state == RUN);
  assign enable_halt        = !done;
  assign err                = r_err;

  assign inst_addr  = r_inst_addr;
  assign inst_data1 = r_inst_d1;
  assign inst_data2 = r_inst_d2;
  assign data_addr  = r_data_addr;
  assign data_data1 = r_data_d1;
  assign data_data2 = r_data_d2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sec_end   <= 1'b0;
      r_err       <= 1'b0;
      r_inst_addr <= '0;
      r_data_addr <= '0;
      r_inst_d1   <= '0;
      r_inst_d2   <= '0;
      r_data_d1   <= '0;
      r_data_d2   <= '0;
    end else begin
      case (r_state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            r_state     <= I_W1;
            r_err       <= 1'b0;
            r_inst_addr <= '0;
            r_data_addr <= '0;
          end
        end
        I_W1: begin
          if (w_accept) begin
            r_inst_d1 <= s_data;
            if (s_last) begin
              // odd-length section: pad the second word with zero
              r_inst_d2 <= '0;
              r_sec_end <= 1'b1;
              r_state   <= I_WR;
            end else begin
              r_sec_end <= 1'b0;
              r_state   <= I_W2;
            end
          end
        end
        I_W2: begin
          if (w_accept) begin
            r_inst_d2 <= s_data;
            r_sec_end <= s_last;
            r_state   <= I_WR;
          end
        end
        I_WR: begin
          if (r_sec_end) begin
            r_data_addr <= '0;
            r_state     <= D_W1;
          end else if (w_inst_full) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end else begin
            r_inst_addr <= r_inst_addr + 1'b1;
            r_state     <= I_W1;
          end
        end
        D_W1: begin
          if (w_accept) begin
            r_data_d1 <= s_data;
            if (s_last) begin
              r_data_d2 <= '0;
              r_sec_end <= 1'b1;
              r_state   <= D_WR;
            end else begin
              r_sec_end <= 1'b0;
              r_state   <= D_W2;
            end
          end
        end
        D_W2: begin
          if (w_accept) begin
            r_data_d2 <= s_data;
            r_sec_end <= s_last;
            r_state   <= D_WR;
          end
        end
        D_WR: begin
          if (r_sec_end) begin
            r_state <= RUN;
          end else if (w_data_full) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end else begin
            r_data_addr <= r_data_addr + 1'b1;
            r_state     <= D_W1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_loader.sv
module tb_ex_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, enable_load_ex_mem, enable_halt;
  logic        inst_we, data_we, busy, done, err;
  logic [8:0]  inst_addr, data_addr;
  logic [31:0] inst_data1, inst_data2, data_data1, data_data2;

  always #5 clk = ~clk;

  ex_mem_loader #(.ADDR_W(9), .DATA_W(32), .INST_DEPTH(4), .DATA_DEPTH(512)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .enable_load_ex_mem(enable_load_ex_mem), .enable_halt(enable_halt),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_data1(inst_data1), .inst_data2(inst_data2),
    .data_we(data_we), .data_addr(data_addr), .data_data1(data_data1), .data_data2(data_data2),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_viol = 0;
  bit stall = 0;
  logic [72:0] iq[$];
  logic [72:0] dq[$];

  // Write-port monitor: records every pair write and flags s_ready during a write cycle
  always @(negedge clk) begin
    if (inst_we) iq.push_back({inst_addr, inst_data1, inst_data2});
    if (data_we) dq.push_back({data_addr, data_data1, data_data2});
    if ((inst_we || data_we) && s_ready) wr_viol++;
    if (inst_we && data_we) wr_viol++;
  end

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int cnt = 0;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!s_ready) chk("send_accept", s_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cnt = 0;
    while (!done && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  function automatic logic [72:0] pr(input int a, input logic [31:0] w1, input logic [31:0] w2);
    logic [8:0] a9;
    a9 = a[8:0];
    return {a9, w1, w2};
  endfunction

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {enable_halt, enable_load_ex_mem, s_ready, busy, done, err, inst_we, data_we}, 8'b1000_0000);
    chk("rst_regs", {inst_addr, data_addr, inst_data1, data_data2}, '0);
    reset = 1'b0;

    // ---- basic load ----
    pulse_start();
    chk("start_ctrl", {enable_halt, enable_load_ex_mem, busy, done, err, s_ready}, 6'b111001);
    send(32'h00000013, 0);
    send(32'h00100093, 0);
    send(32'h00200113, 1);
    send(32'hDEADBEEF, 0);
    send(32'h12345678, 1);
    wait_done();
    chk("t1_icount", iq.size(), 2);
    chk("t1_ipair0", iq[0], pr(0, 32'h00000013, 32'h00100093));
    chk("t1_ipair1", iq[1], pr(1, 32'h00200113, 32'h0));
    chk("t1_dcount", dq.size(), 1);
    chk("t1_dpair0", dq[0], pr(0, 32'hDEADBEEF, 32'h12345678));
    chk("t1_run_ctrl", {enable_halt, enable_load_ex_mem, done, busy, s_ready}, 5'b00100);
    chk("t1_addr_hold", {inst_addr, data_addr}, {9'd1, 9'd0});

    // ---- reload from RUN ----
    iq.delete();
    dq.delete();
    pulse_start();
    chk("t4_ctrl", {enable_halt, done, err, enable_load_ex_mem}, 4'b1001);
    chk("t4_iaddr", inst_addr, 9'd0);

    // ---- stalled stream within the reload ----
    stall = 1;
    send(32'hA0000001, 0);
    send(32'hA0000002, 0);
    send(32'hA0000003, 0);
    send(32'hA0000004, 0);
    send(32'hA0000005, 1);
    send(32'hB0000001, 0);
    send(32'hB0000002, 0);
    send(32'hB0000003, 1);
    stall = 0;
    wait_done();
    chk("t2_icount", iq.size(), 3);
    chk("t2_ipair0", iq[0], pr(0, 32'hA0000001, 32'hA0000002));
    chk("t2_ipair1", iq[1], pr(1, 32'hA0000003, 32'hA0000004));
    chk("t2_ipair2", iq[2], pr(2, 32'hA0000005, 32'h0));
    chk("t2_dcount", dq.size(), 2);
    chk("t2_dpair0", dq[0], pr(0, 32'hB0000001, 32'hB0000002));
    chk("t2_dpair1", dq[1], pr(1, 32'hB0000003, 32'h0));
    chk("t2_wr_ready_low", wr_viol, 0);

    // ---- start during I_W2 is ignored ----
    iq.delete();
    dq.delete();
    pulse_start();
    send(32'hC0000001, 0);
    pulse_start();
    chk("t6_still_loading", {s_ready, busy, inst_we}, 3'b110);
    send(32'hC0000002, 1);
    send(32'hD0000001, 1);
    wait_done();
    chk("t6_icount", iq.size(), 1);
    chk("t6_ipair0", iq[0], pr(0, 32'hC0000001, 32'hC0000002));
    chk("t6_dpair0", dq[0], pr(0, 32'hD0000001, 32'h0));

    // ---- instruction overflow (depth 4) ----
    iq.delete();
    dq.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send(32'h100 + i, 0);
    @(negedge clk);
    chk("t3_err_ctrl", {err, enable_halt, enable_load_ex_mem, s_ready, busy, done}, 6'b110000);
    chk("t3_icount", iq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w1, w2;
      w1 = 32'h100 + 2 * i;
      w2 = 32'h101 + 2 * i;
      chk($sformatf("t3_ipair%0d", i), iq[i], pr(i, w1, w2));
    end
    s_valid = 1'b1;
    s_data  = 32'h108;
    repeat (4) @(negedge clk);
    chk("t3_no_accept", {s_ready, err}, 2'b01);
    s_valid = 1'b0;
    chk("t3_icount_after", iq.size(), 4);
    pulse_start();
    chk("t3_err_cleared", {err, busy}, 2'b01);

    // ---- reset during D_W2 ----
    send(32'hE0000001, 1);
    send(32'hF0000001, 0);
    chk("t5_in_dw2", {s_ready, data_data1}, {1'b1, 32'hF0000001});
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_ctrl", {enable_halt, enable_load_ex_mem, s_ready, busy, done, err, inst_we, data_we}, 8'b1000_0000);
    chk("t5_rst_regs", {inst_data1, data_data1, data_addr}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle", {busy, enable_halt, done}, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
